// File: rtl/cbus_line_initiator.sv
// CBus whole-line initiator: one fill (WRAP) or writeback (INCR) burst per request.
// Optional watchdog enabled by defining CBUS_INITIATOR_TIMEOUT_EN (limit TIMEOUT_CYCLES).
package cbus_pkg;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] data;
    logic        last;
  } cbus_resp_t;
endpackage

module cbus_line_initiator
  import cbus_pkg::*;
#(
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_write,
  input  logic [63:0]              req_addr,
  input  logic [64*LINE_WORDS-1:0] req_wdata,
  output logic                     resp_valid,
  output logic [64*LINE_WORDS-1:0] resp_rdata,
  output logic                     resp_err,
  output cbus_req_t                oreq,
  input  cbus_resp_t               oresp,
  output logic [1:0]               o_dbg_state
);
  localparam int               IDX_W     = $clog2(LINE_WORDS);
  localparam int               LINE_W    = 64 * LINE_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [63:0]      LINE_MASK = ~((64'd1 << (3 + IDX_W)) - 64'd1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (LINE_WORDS < 2 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cbus_line_initiator: LINE_WORDS must be a power of two in 2..16");
  end

  // Handshakes: a request transfers on req_valid && req_ready at a rising edge;
  // a CBus beat transfers on oreq.valid && oresp.ready at a rising edge.
  logic [1:0]        r_state;
  logic              r_is_write;
  logic [63:3]       r_addr;
  logic [IDX_W-1:0]  r_start;
  logic [IDX_W-1:0]  r_k;
  logic              r_overrun;
  logic              r_resp_valid;
  logic [LINE_W-1:0] r_resp_rdata;
  logic              r_err;
  logic [63:0]       r_buf [LINE_WORDS];

  logic              w_accept;
  logic              w_beat;
  logic              w_timeout;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [LINE_W-1:0] w_buf_flat;
  logic              w_unused_addr;

  assign w_accept      = (r_state == S_IDLE) && req_valid;
  assign w_beat        = (r_state == S_BUSY) && oresp.ready;
  assign w_wr_idx      = r_start + r_k;
  assign w_unused_addr = ^req_addr[2:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_start      <= '0;
      r_k          <= '0;
      r_overrun    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_timeout) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_write <= req_is_write;
            r_addr     <= req_addr[63:3];
            r_start    <= req_addr[3+IDX_W-1:3];
            r_k        <= '0;
            r_overrun  <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (oresp.ready) begin
            if (oresp.last) begin
              r_state <= S_DONE;
              if (r_overrun || (r_k != LAST_IDX)) r_err <= 1'b1;
            end else if (r_k == LAST_IDX) begin
              // Responder ran past the line: hold k and drop further data.
              r_overrun <= 1'b1;
              r_err     <= 1'b1;
            end else begin
              r_k <= r_k + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          r_resp_valid <= 1'b1;
          if (!r_is_write) r_resp_rdata <= w_buf_flat;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line buffer carries no reset; its contents are only exposed after a full transaction.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < LINE_WORDS; i++) r_buf[i] <= req_wdata[64*i +: 64];
    end else if (w_beat && !r_is_write && !r_overrun) begin
      r_buf[w_wr_idx] <= oresp.data;
    end
  end

  always_comb begin
    w_buf_flat = '0;
    for (int i = 0; i < LINE_WORDS; i++) w_buf_flat[64*i +: 64] = r_buf[i];
  end

  always_comb begin
    oreq = '0;
    if (r_state == S_BUSY) begin
      oreq.valid    = 1'b1;
      oreq.is_write = r_is_write;
      oreq.len      = 8'(LINE_WORDS - 1);
      oreq.size     = 3'd3;
      if (r_is_write) begin
        oreq.burst  = AXI_BURST_INCR;
        oreq.addr   = {r_addr, 3'b000} & LINE_MASK;
        oreq.data   = r_buf[r_k];
        oreq.strobe = 8'hff;
      end else begin
        // Critical word first: the responder wraps from the requested word.
        oreq.burst = AXI_BURST_WRAP;
        oreq.addr  = {r_addr, 3'b000};
      end
    end
  end

`ifdef CBUS_INITIATOR_TIMEOUT_EN
  logic [31:0] r_timeout_cnt;

  assign w_timeout = (r_state == S_BUSY) && (r_timeout_cnt + 32'd1 == 32'(TIMEOUT_CYCLES)) &&
                     !(oresp.ready && oresp.last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timeout_cnt <= '0;
    end else if (w_accept) begin
      r_timeout_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_timeout_cnt <= r_timeout_cnt + 32'd1;
      if (w_timeout) begin
        $display("ERROR: CBus initiator timeout at %x", oreq.addr);
        $finish;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_err;
  assign o_dbg_state = r_state;

endmodule
